// File: rtl/ram_dp_banked.sv
// rtl/ram_dp_banked.sv - dual-port lane-masked scratchpad RAM with clear engine
module ram_dp_banked #(
    parameter int AWIDTH       = 10,
    parameter int DEPTH        = 1024,
    parameter int DESIGN_SIZE  = 16,
    parameter int DWIDTH       = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear,
    output logic                          busy,
    input  logic [AWIDTH-1:0]             addr0,
    input  logic [AWIDTH-1:0]             addr1,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] d0,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] d1,
    input  logic [DESIGN_SIZE-1:0]        we0,
    input  logic [DESIGN_SIZE-1:0]        we1,
    input  logic                          re0,
    input  logic                          re1,
    output logic [DESIGN_SIZE*DWIDTH-1:0] q0,
    output logic [DESIGN_SIZE*DWIDTH-1:0] q1,
    output logic                          qv0,
    output logic                          qv1,
    output logic                          collision,
    output logic                          oor_err
);
    localparam int WW = DESIGN_SIZE * DWIDTH;
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic [WW-1:0]     mem [DEPTH];

    logic              act, ok0, ok1, rd0, rd1;
    logic [DESIGN_SIZE-1:0] wen0, wen1;
    logic [WW-1:0]     rdata0_d, rdata1_d;
    logic [WW-1:0]     s1_d0_q, s1_d1_q;
    logic              s1_v0_q, s1_v1_q;
    logic              coll_q, oor_q;

    assign busy = (state_q == ST_CLEAR);
    assign act  = (state_q == ST_IDLE);
    assign ok0  = ({1'b0, addr0} < DEPTH_W);
    assign ok1  = ({1'b0, addr1} < DEPTH_W);
    assign wen0 = (act && ok0) ? we0 : '0;
    assign wen1 = (act && ok1) ? we1 : '0;
    assign rd0  = act && re0;
    assign rd1  = act && re1;

    // Write-through overlays this cycle's writes in port priority order (port 0 last, so it wins).
    function automatic logic [WW-1:0] read_word(input logic [AWIDTH-1:0] a, input logic ok);
        logic [WW-1:0] w;
        w = ok ? mem[a] : '0;
        if (RDW_MODE != 0 && ok) begin
            for (int j = 0; j < DESIGN_SIZE; j++) begin
                if (addr1 == a && wen1[j]) w[j*DWIDTH +: DWIDTH] = d1[j*DWIDTH +: DWIDTH];
                if (addr0 == a && wen0[j]) w[j*DWIDTH +: DWIDTH] = d0[j*DWIDTH +: DWIDTH];
            end
        end
        return w;
    endfunction

    assign rdata0_d = read_word(addr0, ok0);
    assign rdata1_d = read_word(addr1, ok1);

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int j = 0; j < DESIGN_SIZE; j++)
                if (wen1[j]) mem[addr1][j*DWIDTH +: DWIDTH] <= d1[j*DWIDTH +: DWIDTH];
            for (int j = 0; j < DESIGN_SIZE; j++)
                if (wen0[j]) mem[addr0][j*DWIDTH +: DWIDTH] <= d0[j*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            s1_v0_q <= 1'b0;
            s1_v1_q <= 1'b0;
            s1_d0_q <= '0;
            s1_d1_q <= '0;
            coll_q  <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            s1_v0_q <= rd0;
            s1_v1_q <= rd1;
            if (rd0) s1_d0_q <= rdata0_d;
            if (rd1) s1_d1_q <= rdata1_d;
            coll_q  <= act && ok0 && ok1 && (addr0 == addr1) && (|(we0 & we1));
            oor_q   <= act && ((!ok0 && (re0 || (|we0))) || (!ok1 && (re1 || (|we1))));
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST) state_q <= ST_IDLE;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign collision = coll_q;
    assign oor_err   = oor_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WW-1:0] q0_q, q1_q;
        logic          qv0_q, qv1_q;
        always_ff @(posedge clk) begin
            if (!resetn) begin
                q0_q  <= '0;
                q1_q  <= '0;
                qv0_q <= 1'b0;
                qv1_q <= 1'b0;
            end else begin
                qv0_q <= s1_v0_q;
                qv1_q <= s1_v1_q;
                if (s1_v0_q) q0_q <= s1_d0_q;
                if (s1_v1_q) q1_q <= s1_d1_q;
            end
        end
        assign q0  = q0_q;
        assign q1  = q1_q;
        assign qv0 = qv0_q;
        assign qv1 = qv1_q;
    end else begin : g_lat1
        assign q0  = s1_d0_q;
        assign q1  = s1_d1_q;
        assign qv0 = s1_v0_q;
        assign qv1 = s1_v1_q;
    end
endmodule

// File: tb/tb_ram_dp_banked.sv
// tb/tb_ram_dp_banked.sv - directed bench: two configurations driven by shared stimulus
module tb_ram_dp_banked;
    logic         clk = 1'b0;
    logic         resetn, clear;
    logic [3:0]   addr0, addr1;
    logic [127:0] d0, d1;
    logic [15:0]  we0, we1;
    logic         re0, re1;

    logic         a_busy, a_qv0, a_qv1, a_coll, a_oor;
    logic [127:0] a_q0, a_q1;
    logic         b_busy, b_qv0, b_qv1, b_coll, b_oor;
    logic [127:0] b_q0, b_q1;

    int checks = 0;
    int failures = 0;
    logic [127:0] wdata [16];
    logic [127:0] exp5, bexp;
    int na, nb;

    always #5 clk = ~clk;

    // A: DEPTH 16, latency 1, read-old-data.  B: DEPTH 12, latency 2, write-through.
    ram_dp_banked #(.AWIDTH(4), .DEPTH(16), .DESIGN_SIZE(16), .DWIDTH(8),
                    .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear), .busy(a_busy),
        .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1), .we0(we0), .we1(we1),
        .re0(re0), .re1(re1), .q0(a_q0), .q1(a_q1), .qv0(a_qv0), .qv1(a_qv1),
        .collision(a_coll), .oor_err(a_oor));

    ram_dp_banked #(.AWIDTH(4), .DEPTH(12), .DESIGN_SIZE(16), .DWIDTH(8),
                    .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear), .busy(b_busy),
        .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1), .we0(we0), .we1(we1),
        .re0(re0), .re1(re1), .q0(b_q0), .q1(b_q1), .qv0(b_qv0), .qv1(b_qv1),
        .collision(b_coll), .oor_err(b_oor));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic idle();
        we0 = '0; we1 = '0; re0 = 1'b0; re1 = 1'b0; clear = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        na = 0; nb = 0;
        for (int k = 0; k < 64 && (a_busy || b_busy); k++) begin
            if (a_busy) na++;
            if (b_busy) nb++;
            @(negedge clk);
        end
        check({tag, "_busy_a"}, 128'(na), 128'(16));
        check({tag, "_busy_b"}, 128'(nb), 128'(12));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        addr0 = '0; addr1 = '0; d0 = '0; d1 = '0; resetn = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_qv0", 128'(a_qv0), 128'(0));
        check("rst_q0", a_q0, 128'(0));
        check("rst_coll", 128'(a_coll), 128'(0));
        check("rst_oor", 128'(a_oor), 128'(0));
        check("rst_b_qv1", 128'(b_qv1), 128'(0));
        check("rst_busy", 128'(a_busy), 128'(1));

        // T1: clear engine after reset release
        resetn = 1'b1;
        count_busy("t1");
        re0 = 1'b1; addr0 = 4'd0; re1 = 1'b1; addr1 = 4'd11;
        @(negedge clk);
        check("t1_a_qv0", 128'(a_qv0), 128'(1));
        check("t1_a_q0", a_q0, 128'(0));
        check("t1_a_q1", a_q1, 128'(0));
        idle();
        @(negedge clk);
        check("t1_a_qv0_off", 128'(a_qv0), 128'(0));
        check("t1_b_qv0", 128'(b_qv0), 128'(1));
        check("t1_b_q0", b_q0, 128'(0));
        check("t1_b_q1", b_q1, 128'(0));
        @(negedge clk);

        // T2: port 1 fills, port 0 streams back
        for (int i = 0; i < 16; i++) begin
            wdata[i] = {$urandom, $urandom, $urandom, $urandom};
            addr1 = 4'(i); d1 = wdata[i]; we1 = '1;
            @(negedge clk);
            if (i == 11) check("t2_b_oor_in", 128'(b_oor), 128'(0));
            if (i == 12) check("t2_b_oor_out", 128'(b_oor), 128'(1));
        end
        idle();
        for (int i = 0; i < 18; i++) begin
            re0 = (i < 16); addr0 = 4'(i % 16);
            @(negedge clk);
            if (i < 16) begin
                check($sformatf("t2_a_qv0_%0d", i), 128'(a_qv0), 128'(1));
                check($sformatf("t2_a_q0_%0d", i), a_q0, wdata[i]);
            end
            if (i == 16) check("t2_a_qv0_end", 128'(a_qv0), 128'(0));
            if (i >= 1 && i <= 16) begin
                bexp = (i - 1 < 12) ? wdata[i-1] : 128'(0);
                check($sformatf("t2_b_qv0_%0d", i - 1), 128'(b_qv0), 128'(1));
                check($sformatf("t2_b_q0_%0d", i - 1), b_q0, bexp);
            end
        end
        idle();

        // T3: write collision on address 5
        addr0 = 4'd5; addr1 = 4'd5;
        we0 = 16'h00FF; d0 = fill(8'hAA);
        we1 = 16'h0FF0; d1 = fill(8'h55);
        @(negedge clk);
        check("t3_a_coll", 128'(a_coll), 128'(1));
        check("t3_b_coll", 128'(b_coll), 128'(1));
        idle();
        re0 = 1'b1; addr0 = 4'd5;
        @(negedge clk);
        check("t3_a_coll_off", 128'(a_coll), 128'(0));
        exp5 = {wdata[5][127:96], {4{8'h55}}, {8{8'hAA}}};
        check("t3_a_mem5", a_q0, exp5);
        idle();
        @(negedge clk);
        check("t3_b_mem5", b_q0, exp5);

        // T4: read-during-write on address 3
        addr0 = 4'd3; d0 = fill(8'h11); we0 = '1;
        @(negedge clk);
        d0 = fill(8'h22); we0 = '1; re1 = 1'b1; addr1 = 4'd3;
        @(negedge clk);
        check("t4_a_rdw_old", a_q1, fill(8'h11));
        idle();
        re1 = 1'b1; addr1 = 4'd3;
        @(negedge clk);
        check("t4_a_next", a_q1, fill(8'h22));
        check("t4_b_rdw_new", b_q1, fill(8'h22));
        idle();
        @(negedge clk);
        check("t4_b_next", b_q1, fill(8'h22));
        check("t4_b_qv1", 128'(b_qv1), 128'(1));

        // T5: out-of-range access on B (address 13 >= 12)
        addr0 = 4'd13; d0 = fill(8'hEE); we0 = '1;
        @(negedge clk);
        check("t5_b_oor_wr", 128'(b_oor), 128'(1));
        check("t5_a_oor_wr", 128'(a_oor), 128'(0));
        idle();
        re0 = 1'b1; addr0 = 4'd13;
        @(negedge clk);
        check("t5_b_oor_rd", 128'(b_oor), 128'(1));
        check("t5_a_q0", a_q0, fill(8'hEE));
        idle();
        @(negedge clk);
        check("t5_b_q0", b_q0, 128'(0));
        check("t5_b_qv0", 128'(b_qv0), 128'(1));
        check("t5_b_oor_off", 128'(b_oor), 128'(0));
        for (int i = 0; i < 13; i++) begin
            re0 = (i < 12); addr0 = 4'(i % 12);
            @(negedge clk);
            if (i >= 1) begin
                bexp = (i - 1 == 5) ? exp5 : (i - 1 == 3) ? fill(8'h22) : wdata[i-1];
                check($sformatf("t5_b_keep_%0d", i - 1), b_q0, bexp);
            end
        end
        idle();

        // T6: clear pulse, ignored re-pulse, then reset at cnt=7
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6_busy", 128'(a_busy), 128'(1));
        re0 = 1'b1; addr0 = 4'd2;
        for (int k = 0; k < 7; k++) begin
            clear = (k == 2);
            @(negedge clk);
            check($sformatf("t6_qv_busy_%0d", k), 128'(a_qv0), 128'(0));
        end
        check("t6_q_hold", a_q0, wdata[11]);
        idle();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        count_busy("t6");
        for (int i = 0; i < 18; i++) begin
            re0 = (i < 16); addr0 = 4'(i % 16);
            @(negedge clk);
            if (i < 16) check($sformatf("t6_a_zero_%0d", i), a_q0, 128'(0));
            if (i >= 1 && i <= 16) check($sformatf("t6_b_zero_%0d", i - 1), b_q0, 128'(0));
        end
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
